// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
//
// Produces the hold/squash controls for the pipeline registers, the E-stage
// forwarding selects, the data-memory wait-state sequencer, a sticky
// memory-timeout flag and a saturating stall-cycle counter.
//
// Ports
//   clk, rst                      rising-edge clock, async active-low reset
//   d_rs1/d_rs2, d_use_rs1/2      D-stage source registers and their use flags
//   e_rd, e_rs1, e_rs2            E-stage destination / sources
//   e_is_load, e_jb               E-stage load flag, branch-taken / jump
//   m_rd, m_reg_we, m_mem_req     M-stage destination, RF write, memory request
//   mem_ack                       data memory completes this cycle
//   w_rd, w_reg_we                W-stage destination, RF write
//   stall_F/D/E/M                 hold PC / Reg_D / Reg_E / Reg_M
//   flush_D, flush_E              load NOP into Reg_D / bubble into Reg_E
//   fwd_rs1_sel, fwd_rs2_sel      00 regfile, 01 from M, 10 from W
//   mem_err                       sticky memory-timeout flag
//   stall_cnt                     cycles with stall_F=1, saturating
module hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       e_rd,
    input  logic [4:0]       e_rs1,
    input  logic [4:0]       e_rs2,
    input  logic             e_is_load,
    input  logic             e_jb,
    input  logic [4:0]       m_rd,
    input  logic             m_reg_we,
    input  logic             m_mem_req,
    input  logic             mem_ack,
    input  logic [4:0]       w_rd,
    input  logic             w_reg_we,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             stall_E,
    output logic             flush_E,
    output logic             stall_M,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // Wide enough to hold MEM_WAIT_MAX itself.
    localparam int WC_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;

    logic mw;
    logic mem_stall;
    logic lu;

    assign mw = m_mem_req & ~mem_ack;

    // Release is combinational in the ack cycle, so a zero-latency ack never stalls.
    assign mem_stall = ((state == RUN) & mw)
                     | ((state == MEM_WAIT) & ~mem_ack)
                     | (state == ERR);

    assign lu = e_is_load & (e_rd != 5'd0)
              & ((d_use_rs1 & (d_rs1 == e_rd)) | (d_use_rs2 & (d_rs2 == e_rd)));

    // Wait-state sequencer; ERR is terminal until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(MEM_WAIT_MAX)) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Priority mem_stall > e_jb > lu. A branch resolving while memory stalls
    // stays held in Reg_E and takes effect once the stall releases.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
            end else if (e_jb) begin
                // D instruction is wrong-path, so any load-use on it is moot.
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (lu) begin
                // Hold F/D one cycle and let the load advance with a bubble behind it.
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (m_reg_we && (m_rd != 5'd0) && (m_rd == rs))
            return 2'b01;
        else if (w_reg_we && (w_rd != 5'd0) && (w_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign fwd_rs1_sel = rst ? fwd_sel(e_rs1) : 2'b00;
    assign fwd_rs2_sel = rst ? fwd_sel(e_rs2) : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall_F && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed bench for hazard_ctrl (MEM_WAIT_MAX=4, CNT_W=4 so
// both the timeout and the counter saturation are reachable quickly).
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] d_rs1, d_rs2, e_rd, e_rs1, e_rs2, m_rd, w_rd;
    logic       d_use_rs1, d_use_rs2, e_is_load, e_jb;
    logic       m_reg_we, m_mem_req, mem_ack, w_reg_we;
    logic       stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, mem_err;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_rd(e_rd), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_is_load(e_is_load), .e_jb(e_jb),
        .m_rd(m_rd), .m_reg_we(m_reg_we), .m_mem_req(m_mem_req), .mem_ack(mem_ack),
        .w_rd(w_rd), .w_reg_we(w_reg_we),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .stall_E(stall_E),
        .flush_E(flush_E), .stall_M(stall_M),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        d_rs1 = 0; d_rs2 = 0; e_rd = 0; e_rs1 = 0; e_rs2 = 0; m_rd = 0; w_rd = 0;
        d_use_rs1 = 0; d_use_rs2 = 0; e_is_load = 0; e_jb = 0;
        m_reg_we = 0; m_mem_req = 0; mem_ack = 0; w_reg_we = 0;
    endtask

    // Advance past the next rising edge; inputs are then changed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
    function automatic logic [5:0] ctl();
        return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E};
    endfunction

    initial begin
        clr();
        rst = 1'b0;
        m_mem_req = 1'b1;   // would stall if reset did not force outputs low
        e_jb = 1'b1;
        #3;
        check("rst_ctl", 32'(ctl()), 32'h0);
        check("rst_cnt", 32'(stall_cnt), 32'h0);
        check("rst_err", 32'(mem_err), 32'h0);
        clr();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Load-use on rs1: one bubble.
        e_is_load = 1; e_rd = 5; d_use_rs1 = 1; d_rs1 = 5;
        #1 check("lu_rs1_ctl", 32'(ctl()), 32'b110001);
        tick(); clr();
        #1 check("lu_after", 32'(stall_F), 32'h0);
        check("lu_cnt", 32'(stall_cnt), 32'd1);

        // Load-use on rs2.
        e_is_load = 1; e_rd = 9; d_use_rs2 = 1; d_rs2 = 9; d_rs1 = 9;
        #1 check("lu_rs2_ctl", 32'(ctl()), 32'b110001);
        tick(); clr();
        #1 check("lu_rs2_cnt", 32'(stall_cnt), 32'd2);

        // Loaded register is x0: no hazard.
        e_is_load = 1; e_rd = 0; d_use_rs1 = 1; d_rs1 = 0;
        #1 check("lu_x0", 32'(ctl()), 32'h0);
        // Match but operand unused: no hazard.
        e_rd = 3; d_rs1 = 3; d_use_rs1 = 0;
        #1 check("lu_unused", 32'(ctl()), 32'h0);
        tick(); clr();

        // Branch overrides load-use.
        e_is_load = 1; e_rd = 5; d_use_rs1 = 1; d_rs1 = 5; e_jb = 1;
        #1 check("jb_ctl", 32'(ctl()), 32'b000011);
        tick(); clr();
        #1 check("jb_cnt", 32'(stall_cnt), 32'd2);

        // Memory wait: 3 cycles of ack low, branch held during the stall.
        m_mem_req = 1; mem_ack = 0; e_jb = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("mw_ctl%0d", i), 32'(ctl()), 32'b111100);
            tick();
        end
        mem_ack = 1;
        #1 check("mw_release", 32'(ctl()), 32'b000011);
        tick(); clr();
        #1 check("mw_cnt", 32'(stall_cnt), 32'd5);
        check("mw_idle", 32'(ctl()), 32'h0);

        // Zero-latency ack: no stall.
        m_mem_req = 1; mem_ack = 1;
        #1 check("ack0", 32'(ctl()), 32'h0);
        tick(); clr();
        #1 check("ack0_cnt", 32'(stall_cnt), 32'd5);

        // Forwarding.
        e_rs1 = 7; m_rd = 7; w_rd = 7; m_reg_we = 1; w_reg_we = 1;
        #1 check("fwd_m_pri", 32'(fwd_rs1_sel), 32'b01);
        m_reg_we = 0;
        #1 check("fwd_w", 32'(fwd_rs1_sel), 32'b10);
        m_reg_we = 1; m_rd = 0; w_rd = 0; e_rs1 = 0;
        #1 check("fwd_x0", 32'(fwd_rs1_sel), 32'b00);
        e_rs2 = 12; m_rd = 11; w_rd = 12;
        #1 check("fwd_rs2_w", 32'(fwd_rs2_sel), 32'b10);
        m_rd = 12;
        #1 check("fwd_rs2_m", 32'(fwd_rs2_sel), 32'b01);
        w_reg_we = 0; m_reg_we = 0;
        #1 check("fwd_rs2_none", 32'(fwd_rs2_sel), 32'b00);
        clr();
        tick();

        // Reset in the middle of a memory wait.
        m_mem_req = 1; mem_ack = 0;
        tick(); tick();
        #1 check("mw_pre_rst", 32'(stall_F), 32'h1);
        rst = 0;
        #1 check("mw_rst_ctl", 32'(ctl()), 32'h0);
        check("mw_rst_cnt", 32'(stall_cnt), 32'h0);
        m_mem_req = 0;
        @(negedge clk);
        rst = 1;
        tick();
        check("post_rst_ctl", 32'(ctl()), 32'h0);
        check("post_rst_cnt", 32'(stall_cnt), 32'h0);

        // Timeout: RUN cycle + 4 wait cycles, then ERR.
        m_mem_req = 1; mem_ack = 0;
        #1 check("to_stall", 32'(stall_F), 32'h1);
        repeat (4) tick();
        check("to_err_pre", 32'(mem_err), 32'h0);
        tick();
        check("to_err", 32'(mem_err), 32'h1);
        m_mem_req = 0; e_jb = 1;
        #1 check("err_ctl", 32'(ctl()), 32'b111100);
        check("err_cnt", 32'(stall_cnt), 32'd5);
        repeat (12) tick();
        check("cnt_sat", 32'(stall_cnt), 32'd15);
        check("err_stuck", 32'(mem_err), 32'h1);
        rst = 0;
        #1 check("err_rst_ctl", 32'(ctl()), 32'h0);
        check("err_rst_err", 32'(mem_err), 32'h0);
        check("err_rst_cnt", 32'(stall_cnt), 32'h0);
        clr();
        @(negedge clk);
        rst = 1;
        tick();
        check("err_cleared", 32'(ctl()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
